// File: rtl/ifetch_unit.sv
// ifetch_unit
// Instruction fetch stage sitting upstream of the decoder. It owns the program
// counter, issues one word read at a time to instruction memory, and buffers
// the returned {pc, instr} pairs in a small FIFO. A taken branch/jump
// (redirect) reloads the PC and flushes the FIFO. Any in-flight read that
// belongs to the old path is discarded when it returns.
//
// Ports
//   CLK, RST        clock and synchronous active-high reset
//   mem_req_*       registered read request (valid/ready, word address)
//   mem_rsp_*       read response, always accepted in the cycle it is valid
//   redirect_*      one-cycle pulse carrying the new fetch target
//   inst_*          FIFO head towards the decoder (valid/ready, data, pc, pc+4)
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_next
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic          kill;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [31:0]   target;
  logic          push;
  logic          pop;

  // Redirect targets are forced to word alignment.
  assign target = redirect_addr & ~32'h3;

  // A response is only kept when it belongs to the current path: it must
  // arrive in WAIT and not coincide with a redirect.
  assign push = (state == WAIT) && mem_rsp_valid && !redirect_valid;
  assign pop  = inst_valid && inst_ready;

  assign inst_valid   = (count != '0);
  assign inst_data    = data_mem[rd_ptr];
  assign inst_pc      = pc_mem[rd_ptr];
  assign inst_pc_next = inst_pc + 32'd4;

  // Fetch control FSM, PC and FIFO bookkeeping. A new request is only
  // issued while the FIFO has room, so the single outstanding response can
  // always be pushed without a full check. mem_req_addr stays stable from
  // issue until the response, so it doubles as the PC of the fetched word.
  // The redirect assignments at the bottom deliberately override whatever
  // the state case decided for pc and the FIFO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      kill          <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= RESET_PC;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!redirect_valid && (count < FULL)) begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= pc;
          end
        end
        REQ: begin
          // The held request is never withdrawn; a redirect only marks it
          // so that its response will be dropped.
          if (redirect_valid) begin
            kill <= 1'b1;
          end
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (kill || redirect_valid) begin
              state <= DROP;
            end else begin
              state <= WAIT;
              pc    <= pc + 32'd4;
            end
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            state <= mem_rsp_valid ? IDLE : DROP;
          end else if (mem_rsp_valid) begin
            state <= IDLE;
          end
        end
        DROP: begin
          if (mem_rsp_valid) begin
            state <= IDLE;
            kill  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (redirect_valid) begin
        pc     <= target;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr]   <= mem_req_addr;
      data_mem[wr_ptr] <= mem_rsp_data;
    end
  end

endmodule
